rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Parametrised N-way request arbiter, successor to the fixed 8-bit priority
//  encoder: registered one-hot grant plus index, selectable fixed-priority or
//  round-robin mode, grant locking with bounded hold. Arbitrates shared
//  pipeline resources (memory port, HI/LO writeback, bus) among requesters.
// PARAMETERS
//  N        8   number of requesters, N >= 2, need not be a power of 2
//  RR       1   1 = round-robin, 0 = fixed priority (highest index wins)
//  MAX_HOLD 16  max consecutive lock-hold cycles after a win; 0 = unlimited
//  PW       $clog2(N)  index width (derived, do not override)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  en         in   1   arbitration enable; 0 freezes all state
//  req        in   N   request vector, bit i = requester i
//  lock       in   1   holder asks to keep grant next cycle
//  gnt        out  N   registered one-hot grant, all-zero when none
//  gnt_idx    out  PW  index of granted requester, 0 when none
//  gnt_valid  out  1   gnt nonzero
//  gnt_new    out  1   1-cycle pulse: gnt loaded by arbitration, not by hold
// BEHAVIOUR
//  - Reset: gnt=0, gnt_idx=0, gnt_valid=0, gnt_new=0, ptr=0, hold_cnt=0.
//    Reset wins over en and any request; reset mid-grant drops grant next edge.
//  - Internal: ptr (PW bits, RR search start), hold_cnt ($clog2(MAX_HOLD+1)
//    bits, absent when MAX_HOLD=0).
//  - Latency: 1 cycle, req sampled at edge k, gnt visible after edge k.
//  - en=0: every register holds, including gnt_new (gnt_new then stays at
//    its last value).
//  - en=1, per edge, first matching rule:
//    HOLD: gnt_valid & lock & req[gnt_idx] & (MAX_HOLD==0 | hold_cnt<MAX_HOLD)
//      -> gnt/gnt_idx unchanged, hold_cnt++, gnt_new=0.
//    IDLE: req==0 -> gnt=0, gnt_idx=0, gnt_valid=0, gnt_new=0, hold_cnt=0,
//      ptr unchanged.
//    ARB: else winner W, gnt=1<<W, gnt_idx=W, gnt_valid=1, gnt_new=1,
//      hold_cnt=0.
//  - Winner, RR=1: first set req bit scanning ptr, ptr+1 .. N-1, 0 .. ptr-1;
//    then ptr=(W+1) mod N (N-1 wraps to 0, also for non-power-of-2 N).
//  - Winner, RR=0: highest set index; ptr stays 0. If ARB was forced by hold
//    expiry, the previous holder is excluded unless it is the sole requester.
//  - Hold expiry under RR: scan starts at holder+1, so holder wins again only
//    if it is the sole requester. Max tenure under lock = MAX_HOLD+1 cycles.
//  - Grant without lock is one cycle; re-arbitrated every enabled edge.
//  - Holder dropping req with lock=1 -> normal ARB/IDLE that edge.
//  - gnt always one-hot or zero; gnt_valid == |gnt; gnt_idx matches gnt.
//  - Pure combinational scan, no multicycle paths; ptr never >= N.
// TESTING
//  1. reset=1 two cycles, req=all-ones -> gnt=0,gnt_idx=0,gnt_valid=0,gnt_new=0.
//  2. N=4,RR=1,lock=0,req=4'b1111 for 5 cycles -> gnt_idx 0,1,2,3,0;
//     gnt_new=1 every cycle.
//  3. N=4,RR=0,req=4'b0101 -> gnt=4'b0100,gnt_idx=2 steady; req=0 ->
//     gnt_valid=0 next cycle.
//  4. N=4,RR=1,MAX_HOLD=3,lock=1,req=4'b1111 -> idx0 for 4 cycles (gnt_new
//     only on 1st), then idx1; req=4'b0001 with lock -> idx0 re-won at expiry.
//  5. en=0 mid-hold for 3 cycles -> outputs, hold_cnt frozen; reset during
//     grant idx2 -> gnt=0 next edge, next req=4'b1111 grants idx0.
//  6. N=5,RR=1: win idx4, then req=5'b10001 -> idx0 (ptr wrap), then idx4.

Source files
------------

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// Latency: none, wires only; grant side is registered inside the arbiter.
// Backpressure: none; requesters hold req until they see their grant.
interface rr_arbiter_if #(
    parameter int N = 8
);
    localparam int PW = $clog2(N);

    logic          en;
    logic [N-1:0]  req;
    logic          lock;
    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          gnt_new;

    // Requester side drives requests and enable, observes the grant.
    modport master (
        output en, req, lock,
        input  gnt, gnt_idx, gnt_valid, gnt_new
    );

    // Arbiter side.
    modport slave (
        input  en, req, lock,
        output gnt, gnt_idx, gnt_valid, gnt_new
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin or fixed priority, registered one-hot grant with bounded lock hold.
// Latency: 1 cycle, req sampled at edge k gives gnt after edge k.
// Backpressure: en=0 freezes every register; losers simply keep requesting.
module rr_arbiter #(
    parameter  int N        = 8,
    parameter  int RR       = 1,
    parameter  int MAX_HOLD = 16,
    localparam int PW       = $clog2(N)
) (
    input  logic       clk,
    input  logic       reset,
    rr_arbiter_if.slave bus
);
    // Hold counter only needs to reach MAX_HOLD; with unlimited hold it stays at zero.
    localparam int            HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          gnt_new_q, gnt_new_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic          holder_req;
    logic          under_limit;
    logic          hold_ok;
    logic          expired;
    logic [N-1:0]  cand;
    logic          win_found;
    logic [PW-1:0] win_idx;
    int            scan_pos;

    // Decide whether the current holder may keep the grant, and who may compete otherwise.
    always_comb begin
        holder_req  = gnt_valid_q & bus.lock & bus.req[gnt_idx_q];
        under_limit = (MAX_HOLD == 0) || (hold_cnt_q < HW'(MAX_HOLD));
        hold_ok     = holder_req & under_limit;
        expired     = holder_req & ~under_limit;
        cand        = bus.req;
        // Fixed priority would hand an expired holder straight back; skip it unless alone.
        // Round-robin needs no mask: ptr already sits one past the holder.
        if (RR == 0 && expired && bus.req != gnt_q) begin
            cand = bus.req & ~gnt_q;
        end
    end

    // Winner search: rotate from ptr for round-robin, highest index for fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        if (RR != 0) begin
            for (int i = 0; i < N; i++) begin
                scan_pos = int'(ptr_q) + i;
                if (scan_pos >= N) begin
                    scan_pos = scan_pos - N;
                end
                if (!win_found && cand[scan_pos]) begin
                    win_found = 1'b1;
                    win_idx   = PW'(scan_pos);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_idx   = PW'(i);
                end
            end
        end
    end

    // Next-state selection: hold, go idle, or load a fresh arbitration result.
    always_comb begin
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        gnt_new_d   = gnt_new_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        if (bus.en) begin
            if (hold_ok) begin
                gnt_new_d  = 1'b0;
                hold_cnt_d = (MAX_HOLD == 0) ? '0 : hold_cnt_q + HW'(1);
            end else if (bus.req == '0 || !win_found) begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                gnt_new_d   = 1'b0;
                hold_cnt_d  = '0;
            end else begin
                gnt_d       = ONE << win_idx;
                gnt_idx_d   = win_idx;
                gnt_valid_d = 1'b1;
                gnt_new_d   = 1'b1;
                hold_cnt_d  = '0;
                if (RR != 0) begin
                    ptr_d = (win_idx == LAST) ? '0 : win_idx + PW'(1);
                end
            end
        end
    end

    // State registers; reset overrides enable and requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_new_q   <= gnt_new_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_new   = gnt_new_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three configurations share one stimulus stream.
// A: N=4 round-robin hold<=3, B: N=4 fixed priority hold<=3, C: N=5 round-robin unlimited hold.
// Expected outputs per edge are queued by the driver and popped by a negedge monitor.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_arbiter_if #(.N(4)) ifa();
    rr_arbiter_if #(.N(4)) ifb();
    rr_arbiter_if #(.N(5)) ifc();

    rr_arbiter #(.N(4), .RR(1), .MAX_HOLD(3)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    rr_arbiter #(.N(4), .RR(0), .MAX_HOLD(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    rr_arbiter #(.N(5), .RR(1), .MAX_HOLD(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    typedef struct packed {
        logic [2:0][4:0] gnt;
        logic [2:0][2:0] idx;
        logic [2:0]      vld;
        logic [2:0]      nw;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: tenure = cycles the holder has owned the grant so far.
    int cfg_n  [3] = '{4, 4, 5};
    int cfg_rr [3] = '{1, 0, 1};
    int cfg_mh [3] = '{3, 3, 0};
    int m_vld  [3];
    int m_idx  [3];
    int m_ten  [3];
    int m_ptr  [3];
    int m_new  [3];

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit e, input logic [4:0] rq, input bit lk);
        int n, rv, c, w, best, d;
        bit held;
        n  = cfg_n[k];
        rv = int'(rq) & ((1 << n) - 1);
        if (r) begin
            m_vld[k] = 0; m_idx[k] = 0; m_ten[k] = 0; m_ptr[k] = 0; m_new[k] = 0;
        end else if (e) begin
            held = (m_vld[k] != 0) && lk && (((rv >> m_idx[k]) & 1) != 0);
            if (held && (cfg_mh[k] == 0 || m_ten[k] <= cfg_mh[k])) begin
                m_ten[k]++;
                m_new[k] = 0;
            end else if (rv == 0) begin
                m_vld[k] = 0; m_idx[k] = 0; m_ten[k] = 0; m_new[k] = 0;
            end else begin
                w = 0;
                if (cfg_rr[k] != 0) begin
                    // Closest requester at or after ptr in circular distance.
                    best = n;
                    for (int i = 0; i < n; i++) begin
                        d = (i - m_ptr[k] + n) % n;
                        if (((rv >> i) & 1) != 0 && d < best) begin
                            best = d;
                            w    = i;
                        end
                    end
                    m_ptr[k] = (w + 1) % n;
                end else begin
                    c = rv;
                    if (held && rv != (1 << m_idx[k])) c = c & ~(1 << m_idx[k]);
                    for (int i = 0; i < n; i++) if (((c >> i) & 1) != 0) w = i;
                end
                m_vld[k] = 1; m_idx[k] = w; m_new[k] = 1; m_ten[k] = 1;
            end
        end
    endtask

    // Apply one cycle of stimulus, queue the model's prediction, advance past the edge.
    task automatic cycle(input bit r, input bit e, input logic [4:0] rq, input bit lk);
        exp_t x;
        reset    = r;
        ifa.en   = e;  ifb.en   = e;  ifc.en   = e;
        ifa.lock = lk; ifb.lock = lk; ifc.lock = lk;
        ifa.req  = rq[3:0];
        ifb.req  = rq[3:0];
        ifc.req  = rq;
        for (int k = 0; k < 3; k++) begin
            model_step(k, r, e, rq, lk);
            x.gnt[k] = (m_vld[k] != 0) ? 5'(1 << m_idx[k]) : 5'd0;
            x.idx[k] = 3'(m_idx[k]);
            x.vld[k] = (m_vld[k] != 0);
            x.nw[k]  = (m_new[k] != 0);
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Directed check of one instance's outputs against spec-given constants.
    task automatic dchk(input string nm, input int k, input int g, input int idx, input int v, input int nw);
        int ag, ai, av, an;
        case (k)
            0:       begin ag = int'(ifa.gnt); ai = int'(ifa.gnt_idx); av = int'(ifa.gnt_valid); an = int'(ifa.gnt_new); end
            1:       begin ag = int'(ifb.gnt); ai = int'(ifb.gnt_idx); av = int'(ifb.gnt_valid); an = int'(ifb.gnt_new); end
            default: begin ag = int'(ifc.gnt); ai = int'(ifc.gnt_idx); av = int'(ifc.gnt_valid); an = int'(ifc.gnt_new); end
        endcase
        check({nm, " gnt"}, ag, g);
        check({nm, " idx"}, ai, idx);
        check({nm, " valid"}, av, v);
        check({nm, " new"}, an, nw);
    endtask

    // Monitor: compare every DUT against the queued prediction for the last edge.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [2:0][4:0] ag;
        logic [2:0][2:0] ai;
        logic [2:0]      av, an;
        if (exp_q.size() != 0) begin
            e     = exp_q.pop_front();
            ag[0] = {1'b0, ifa.gnt};     ag[1] = {1'b0, ifb.gnt};     ag[2] = ifc.gnt;
            ai[0] = {1'b0, ifa.gnt_idx}; ai[1] = {1'b0, ifb.gnt_idx}; ai[2] = ifc.gnt_idx;
            av    = {ifc.gnt_valid, ifb.gnt_valid, ifa.gnt_valid};
            an    = {ifc.gnt_new, ifb.gnt_new, ifa.gnt_new};
            for (int k = 0; k < 3; k++) begin
                check($sformatf("sb%0d gnt", k), int'(ag[k]), int'(e.gnt[k]));
                check($sformatf("sb%0d idx", k), int'(ai[k]), int'(e.idx[k]));
                check($sformatf("sb%0d valid", k), int'(av[k]), int'(e.vld[k]));
                check($sformatf("sb%0d new", k), int'(an[k]), int'(e.nw[k]));
                check($sformatf("sb%0d valid_vs_gnt", k), int'(av[k]), int'(|ag[k]));
            end
        end
    end

    initial begin
        logic [4:0] rq;
        bit         r, e, lk;

        // Reset with all requests asserted.
        cycle(1, 1, 5'h1F, 0);
        cycle(1, 1, 5'h1F, 0);
        for (int k = 0; k < 3; k++) dchk($sformatf("reset k%0d", k), k, 0, 0, 0, 0);

        // Round-robin rotation without lock.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 5'h1F, 0);
            dchk($sformatf("rr4 c%0d", i), 0, 1 << (i % 4), i % 4, 1, 1);
            dchk($sformatf("rr5 c%0d", i), 2, 1 << i, i, 1, 1);
            dchk($sformatf("fixed c%0d", i), 1, 8, 3, 1, 1);
        end

        // Fixed priority picks the highest index, then idles.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 5'b00101, 0);
            dchk($sformatf("fix0101 c%0d", i), 1, 4, 2, 1, 1);
        end
        cycle(0, 1, 5'b00000, 0);
        dchk("fix idle", 1, 0, 0, 0, 0);

        // Lock with bounded hold: idx0 for 4 cycles, then idx1.
        cycle(1, 1, 5'b00000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 5'b01111, 1);
            dchk($sformatf("hold c%0d", i), 0, (i < 4) ? 1 : 2, (i < 4) ? 0 : 1, 1, (i == 0 || i == 4) ? 1 : 0);
        end
        // Sole requester re-wins at expiry.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 5'b00001, 1);
            dchk($sformatf("sole c%0d", i), 0, 1, 0, 1, (i == 0 || i == 4) ? 1 : 0);
        end

        // Enable low mid-hold freezes outputs and hold count.
        cycle(0, 1, 5'b00001, 1);
        dchk("pre-freeze", 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 5'b00010, 0);
            dchk($sformatf("frozen c%0d", i), 0, 1, 0, 1, 0);
        end
        cycle(0, 1, 5'b00001, 1);
        dchk("resume h3", 0, 1, 0, 1, 0);
        cycle(0, 1, 5'b00001, 1);
        dchk("resume h4", 0, 1, 0, 1, 0);
        cycle(0, 1, 5'b00001, 1);
        dchk("resume expiry", 0, 1, 0, 1, 1);

        // Reset while idx2 holds the grant.
        cycle(0, 1, 5'b00100, 0);
        dchk("pre-reset idx2", 0, 4, 2, 1, 1);
        cycle(1, 1, 5'b01111, 0);
        dchk("reset mid-grant", 0, 0, 0, 0, 0);
        cycle(0, 1, 5'b01111, 0);
        dchk("post-reset", 0, 1, 0, 1, 1);

        // Pointer wrap for N=5.
        cycle(1, 1, 5'b00000, 0);
        cycle(0, 1, 5'b10000, 0);
        dchk("n5 win4", 2, 16, 4, 1, 1);
        cycle(0, 1, 5'b10001, 0);
        dchk("n5 wrap0", 2, 1, 0, 1, 1);
        cycle(0, 1, 5'b10001, 0);
        dchk("n5 then4", 2, 16, 4, 1, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 9) != 0);
            lk = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       rq = 5'd0;
                1:       rq = 5'(1 << $urandom_range(0, 4));
                2:       rq = 5'($urandom);
                default: rq = 5'h1F;
            endcase
            cycle(r, e, rq, lk);
        end

        @(negedge clk);
        #1;
        check("queue drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
